pkt_stream_gen: RTL and testbench
=================================

// Module: pkt_stream_gen
// PURPOSE
//  Parametrised NetFPGA-style packet stream generator for classifier and flow-pipeline benches and on-board self-test.
//  Replays packets held in a programmable word memory as a {data, ctrl} stream with out_wr/out_rdy flow control.
//  Adds a configurable inter-packet gap, a packet-count limit or loop mode, and a periodic ready-throttle output
//  for the DUT's downstream side. Sits between the test controller and the DUT input port.
// PARAMETERS
//  DATA_WIDTH   64   stream data width; multiple of 8
//  CTRL_WIDTH   DATA_WIDTH/8  ctrl width; non-zero ctrl marks a module-header word
//  MEM_DEPTH    64   packet-memory depth in words; power of 2
//  ADDR_W       $clog2(MEM_DEPTH)  memory address width
//  CNT_W        32   width of packet limit and statistics counters
// PORTS
//  clk          in   1           system clock
//  reset        in   1           asynchronous, active-low reset
//  prog_wr      in   1           write one memory word; ignored while busy
//  prog_addr    in   ADDR_W      word address
//  prog_data    in   DATA_WIDTH  word data
//  prog_ctrl    in   CTRL_WIDTH  word ctrl
//  prog_last    in   1           word is the last of its packet
//  mem_words    in   ADDR_W+1    number of valid words, 1..MEM_DEPTH; sampled at start
//  gap_cycles   in   8           idle cycles between packets; sampled at start
//  num_pkts     in   CNT_W       packets to send, 0 = loop until stop; sampled at start
//  rdy_period   in   8           throttle period, 0 = dn_rdy always 1
//  start        in   1           one-cycle pulse, accepted only in IDLE
//  stop         in   1           level; ends the run at the next packet boundary
//  out_data     out  DATA_WIDTH  stream data
//  out_ctrl     out  CTRL_WIDTH  stream ctrl
//  out_wr       out  1           word valid this cycle
//  out_rdy      in   1           sink can accept a word this cycle
//  dn_rdy       out  1           throttle pattern for the DUT's out_rdy
//  busy         out  1           run in progress
//  done         out  1           one-cycle pulse at end of run
//  tx_pkts      out  CNT_W       packets completed since start; wraps
//  tx_words     out  CNT_W       words transferred since start; wraps
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, memory contents undefined. A mid-run reset drops the packet immediately;
//    no done pulse. dn_rdy is 1 on the first cycle after reset release, then follows the throttle pattern.
//  - Memory: MEM_DEPTH x {last, ctrl, data}, synchronous write. Read is combinational from rd_ptr.
//  - Transfer: out_wr = (state==SEND) & out_rdy. out_data/out_ctrl are presented combinationally from mem[rd_ptr].
//    A word transfers on every cycle with out_wr=1. rd_ptr advances only on a transfer.
//  - rd_ptr wraps to 0 after mem_words-1. The word at address mem_words-1 is treated as last even if prog_last=0.
//  - FSM states and transitions:
//      IDLE -> SEND on start: latch config; clear rd_ptr, tx_pkts and tx_words; busy=1.
//      SEND -> on transfer of a last word, tx_pkts++ and then:
//                (stop | (num_pkts!=0 & tx_pkts+1==num_pkts)) -> DONE
//                else if gap_cycles!=0 -> GAP
//                else stay in SEND
//      GAP  -> SEND after gap_cycles cycles (down-counter). A stop seen in GAP -> DONE.
//      DONE -> IDLE after 1 cycle: done=1 and busy=0 in that cycle.
//  - stop never truncates a packet: an in-flight packet completes and is counted.
//  - start while busy is ignored. A start in the DONE cycle is also ignored.
//  - Throttle: free-running thr_cnt counts 0..rdy_period-1. dn_rdy = (thr_cnt != 0) when rdy_period>1;
//    dn_rdy = 1 when rdy_period is 0 or 1. A changed rdy_period restarts thr_cnt at 0.
//  - Counters are CNT_W wide, unsigned, and wrap modulo 2^CNT_W. The num_pkts compare uses the pre-increment tx_pkts.
// STRUCTURE
//  - Shared package pkt_gen_pkg: FSM state encoding (IDLE, SEND, GAP, DONE), the word-record layout
//    {last, ctrl, data} as width localparams, and the CTRL header value 8'hFF.
//  - One sub-module, pkt_gen_throttle, owns thr_cnt and dn_rdy. The FSM, memory and counters stay in the top module.
// TESTING
//  1. Program 2 packets: 14 words (hdr ctrl FF, last at word 13) and 12 words (last at 25); mem_words=26,
//     gap=6, num_pkts=2, out_rdy=1 -> 26 transfers, 6 idle cycles between packets, tx_pkts=2, tx_words=26, one done.
//  2. Same program with out_rdy low every 5th cycle -> the word sequence is identical to case 1 with no word
//     duplicated or skipped; total cycles grow by the number of stalls.
//  3. num_pkts=0, gap=0, stop raised mid-packet 5 -> packet 5 completes, then done; tx_pkts=5 (loop wraps rd_ptr).
//  4. reset asserted during word 7 of packet 1 -> out_wr=0, busy=0, counters=0 asynchronously; a new start replays from word 0.
//  5. rdy_period=5 -> dn_rdy pattern 0,1,1,1,1 repeating; rdy_period=0 -> dn_rdy constantly 1.
//  6. prog_wr and a second start while busy -> memory unchanged and the run unaffected; last-word forcing checked with mem_words=3 and no prog_last.

Source files
------------

// File: rtl/pkt_gen_pkg.sv
// Shared definitions for the packet stream generator.
// Holds the FSM encoding, the memory record layout helpers and the header ctrl value.
package pkt_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } gen_state_t;

    // Each memory record is {last, ctrl, data}, with last in the top bit.
    localparam int REC_LAST_W = 1;
    localparam logic [7:0] CTRL_HDR = 8'hFF;

    function automatic int rec_width(input int data_w, input int ctrl_w);
        return data_w + ctrl_w + REC_LAST_W;
    endfunction

endpackage

// File: rtl/pkt_gen_throttle.sv
// Periodic ready pattern for the downstream side of the DUT.
// Latency: dn_rdy registered; a new rdy_period takes effect one cycle after it changes.
// Backpressure: none; free-running regardless of the stream state.
module pkt_gen_throttle
    import pkt_gen_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rdy_period,
    output logic       dn_rdy
);

    logic [7:0] thr_cnt;
    logic [7:0] thr_nxt;
    logic [7:0] period_q;
    logic       armed_q;

    always_comb begin
        thr_nxt = 8'd0;
        if (period_q > 8'd1 && thr_cnt < period_q - 8'd1)
            thr_nxt = thr_cnt + 8'd1;
    end

    // The first cycle out of reset skips the 0 slot so dn_rdy opens high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_cnt  <= 8'd0;
            period_q <= 8'd0;
            armed_q  <= 1'b0;
            dn_rdy   <= 1'b0;
        end else begin
            armed_q  <= 1'b1;
            period_q <= rdy_period;
            if (!armed_q) begin
                thr_cnt <= (rdy_period > 8'd1) ? 8'd1 : 8'd0;
                dn_rdy  <= 1'b1;
            end else if (rdy_period != period_q) begin
                thr_cnt <= 8'd0;
                dn_rdy  <= (rdy_period <= 8'd1);
            end else begin
                thr_cnt <= thr_nxt;
                dn_rdy  <= (period_q <= 8'd1) || (thr_nxt != 8'd0);
            end
        end
    end

endmodule

// File: rtl/pkt_stream_gen.sv
// Replays programmed packets as a {data, ctrl} stream with gaps, count limit or loop, and stop.
// Latency: a word is presented combinationally from memory the cycle after start is accepted.
// Backpressure: out_rdy low holds the current word; gap timing and throttle are unaffected.
module pkt_stream_gen
    import pkt_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_W     = $clog2(MEM_DEPTH),
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_wr,
    input  logic [ADDR_W-1:0]     prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic [CTRL_WIDTH-1:0] prog_ctrl,
    input  logic                  prog_last,
    input  logic [ADDR_W:0]       mem_words,
    input  logic [7:0]            gap_cycles,
    input  logic [CNT_W-1:0]      num_pkts,
    input  logic [7:0]            rdy_period,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    output logic                  dn_rdy,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      tx_pkts,
    output logic [CNT_W-1:0]      tx_words
);

    localparam int REC_W = rec_width(DATA_WIDTH, CTRL_WIDTH);

    logic [REC_W-1:0]  mem [MEM_DEPTH];
    logic [REC_W-1:0]  rec;
    gen_state_t        state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   words_q;
    logic [ADDR_W:0]   last_addr;
    logic [7:0]        gap_q;
    logic [7:0]        gap_cnt;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  pkts_inc;
    logic              at_end;
    logic              word_last;
    logic              sending;

    always_ff @(posedge clk) begin
        if (prog_wr && !busy)
            mem[prog_addr] <= {prog_last, prog_ctrl, prog_data};
    end

    assign rec       = mem[rd_ptr];
    assign sending   = (state == ST_SEND);
    assign out_wr    = sending & out_rdy;
    assign out_data  = sending ? rec[DATA_WIDTH-1:0] : '0;
    assign out_ctrl  = sending ? rec[DATA_WIDTH +: CTRL_WIDTH] : '0;
    assign last_addr = words_q - (ADDR_W+1)'(1);
    assign at_end    = ({1'b0, rd_ptr} == last_addr);
    // The final valid word always closes a packet so a loop never straddles the wrap.
    assign word_last = rec[REC_W-1] | at_end;
    assign pkts_inc  = tx_pkts + CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            rd_ptr   <= '0;
            words_q  <= '0;
            gap_q    <= '0;
            gap_cnt  <= '0;
            num_q    <= '0;
            tx_pkts  <= '0;
            tx_words <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        words_q  <= mem_words;
                        gap_q    <= gap_cycles;
                        num_q    <= num_pkts;
                        rd_ptr   <= '0;
                        tx_pkts  <= '0;
                        tx_words <= '0;
                        busy     <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_rdy) begin
                        tx_words <= tx_words + CNT_W'(1);
                        rd_ptr   <= at_end ? '0 : rd_ptr + ADDR_W'(1);
                        if (word_last) begin
                            tx_pkts <= pkts_inc;
                            if (stop || (num_q != '0 && pkts_inc == num_q)) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else if (gap_q != 8'd0) begin
                                state   <= ST_GAP;
                                gap_cnt <= gap_q;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (stop) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (gap_cnt <= 8'd1) begin
                        state <= ST_SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    pkt_gen_throttle u_throttle (
        .clk        (clk),
        .reset      (reset),
        .rdy_period (rdy_period),
        .dn_rdy     (dn_rdy)
    );

endmodule

// File: tb/tb_pkt_stream_gen.sv
// Bench for pkt_stream_gen: scoreboard of expected words against the observed stream.
// Each scenario task drives stimulus and compares inline.
module tb_pkt_stream_gen;
    import pkt_gen_pkg::*;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int AW = 6;
    localparam int CN = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          prog_wr, prog_last, start, stop, out_rdy;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic [CW-1:0] prog_ctrl;
    logic [AW:0]   mem_words;
    logic [7:0]    gap_cycles, rdy_period;
    logic [CN-1:0] num_pkts;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr, dn_rdy, busy, done;
    logic [CN-1:0] tx_pkts, tx_words;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]    pd [26];
    logic [CW-1:0]    pc [26];
    logic             pl [26];
    logic [CW+DW-1:0] exp_q [$];
    logic [CW+DW-1:0] got_q [$];
    int done_cyc, c13, c14, stalls;
    bit timed_out;

    pkt_stream_gen dut (
        .clk(clk), .reset(reset), .prog_wr(prog_wr), .prog_addr(prog_addr),
        .prog_data(prog_data), .prog_ctrl(prog_ctrl), .prog_last(prog_last),
        .mem_words(mem_words), .gap_cycles(gap_cycles), .num_pkts(num_pkts),
        .rdy_period(rdy_period), .start(start), .stop(stop),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .dn_rdy(dn_rdy), .busy(busy), .done(done), .tx_pkts(tx_pkts), .tx_words(tx_words)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [CW+DW-1:0] word_of(input int i);
        return {pc[i], pd[i]};
    endfunction

    task automatic program_mem(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            prog_wr = 1'b1; prog_addr = AW'(i);
            prog_data = pd[i]; prog_ctrl = pc[i]; prog_last = pl[i];
            @(negedge clk);
        end
        prog_wr = 1'b0;
    endtask

    task automatic do_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Collects transferred words; ends on the done pulse or when the budget runs out.
    task automatic run_collect(input int budget, input bit stall, input int stop_word,
                               input bit poke, input bit start_in_done, input int gap_model);
        int gap_left = 0;
        got_q.delete();
        done_cyc = -1; c13 = -1; c14 = -1; stalls = 0; timed_out = 1'b1;
        prog_addr = AW'(1); prog_data = 64'hBAD0_BAD0_BAD0_BAD0;
        prog_ctrl = 8'h5A; prog_last = 1'b1;
        for (int c = 0; c < budget; c++) begin
            out_rdy = !(stall && (c % 5 == 4));
            stop = stop | (stop_word > 0 && got_q.size() >= stop_word);
            if (poke) begin
                prog_wr = (c == 1);
                start   = (c == 1);
            end
            #1;
            if (done) begin
                done_cyc = c; timed_out = 1'b0;
                if (start_in_done) start = 1'b1;
                break;
            end
            if (gap_left > 0) gap_left--;
            else if (busy && !out_rdy) stalls++;
            if (out_wr) begin
                got_q.push_back({out_ctrl, out_data});
                if (got_q.size() == 14) begin c13 = c; gap_left = gap_model; end
                if (got_q.size() == 15) c14 = c;
            end
            @(negedge clk);
        end
        prog_wr = 1'b0;
        out_rdy = 1'b1;
    endtask

    task automatic test_reset;
        #23;
        tests++; if (out_wr !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_ctl: wr=%b busy=%b done=%b, want 0 0 0", out_wr, busy, done); end
        tests++; if (tx_pkts !== '0 || tx_words !== '0) begin
            fails++; $display("FAIL reset_cnt: pkts=%0d words=%0d, want 0 0", tx_pkts, tx_words); end
        tests++; if (out_data !== '0 || out_ctrl !== '0 || dn_rdy !== 1'b0) begin
            fails++; $display("FAIL reset_out: data=%h ctrl=%h dn=%b, want 0", out_data, out_ctrl, dn_rdy); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); #1;
        tests++; if (dn_rdy !== 1'b1) begin
            fails++; $display("FAIL reset_dn_rdy: got %b want 1", dn_rdy); end
    endtask

    task automatic test_basic(output int base_cycles);
        logic [CW+DW-1:0] e, g;
        program_mem(26);
        mem_words = 7'd26; gap_cycles = 8'd6; num_pkts = 32'd2;
        for (int i = 0; i < 26; i++) exp_q.push_back(word_of(i));
        do_start();
        run_collect(200, 1'b0, 0, 1'b0, 1'b0, 6);
        base_cycles = done_cyc;
        tests++; if (timed_out) begin fails++; $display("FAIL basic_timeout: no done within 200 cycles"); end
        tests++; if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL basic_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL basic_word: got %h want %h", g, e); end
        end
        exp_q.delete();
        tests++; if (c14 - c13 - 1 != 6) begin
            fails++; $display("FAIL basic_gap: got %0d idle cycles want 6", c14 - c13 - 1); end
        tests++; if (done_cyc != 32) begin
            fails++; $display("FAIL basic_done_cycle: got %0d want 32", done_cyc); end
        tests++; if (tx_pkts !== 32'd2 || tx_words !== 32'd26 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_stats: pkts=%0d words=%0d busy=%b want 2 26 0", tx_pkts, tx_words, busy); end
        @(negedge clk); #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL basic_done_pulse: done=%b want 0", done); end
    endtask

    task automatic test_stall(input int base_cycles);
        logic [CW+DW-1:0] e, g;
        for (int i = 0; i < 26; i++) exp_q.push_back(word_of(i));
        do_start();
        run_collect(300, 1'b1, 0, 1'b0, 1'b0, 6);
        tests++; if (timed_out) begin fails++; $display("FAIL stall_timeout: no done within 300 cycles"); end
        tests++; if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL stall_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL stall_word: got %h want %h", g, e); end
        end
        exp_q.delete();
        tests++; if (stalls == 0 || done_cyc != base_cycles + stalls) begin
            fails++; $display("FAIL stall_cycles: got %0d want %0d (stalls %0d)", done_cyc, base_cycles + stalls, stalls); end
    endtask

    task automatic test_loop_stop;
        logic [CW+DW-1:0] e, g;
        gap_cycles = 8'd0; num_pkts = 32'd0;
        for (int i = 0; i < 66; i++) exp_q.push_back(word_of(i % 26));
        do_start();
        run_collect(300, 1'b0, 55, 1'b0, 1'b0, 0);
        stop = 1'b0;
        tests++; if (timed_out) begin fails++; $display("FAIL loop_timeout: no done within 300 cycles"); end
        tests++; if (got_q.size() != exp_q.size()) begin
            fails++; $display("FAIL loop_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL loop_word: got %h want %h", g, e); end
        end
        exp_q.delete();
        tests++; if (tx_pkts !== 32'd5 || tx_words !== 32'd66) begin
            fails++; $display("FAIL loop_stats: pkts=%0d words=%0d want 5 66", tx_pkts, tx_words); end
    endtask

    task automatic test_mid_reset;
        logic [CW+DW-1:0] e, g;
        int cnt = 0;
        bit seen = 1'b0;
        gap_cycles = 8'd6; num_pkts = 32'd2;
        do_start();
        for (int c = 0; c < 60; c++) begin
            #1;
            if (out_wr) begin
                if (cnt == 7) begin seen = 1'b1; break; end
                cnt++;
            end
            @(negedge clk);
        end
        tests++; if (!seen || out_data !== pd[7]) begin
            fails++; $display("FAIL midrst_word7: seen=%b data=%h want %h", seen, out_data, pd[7]); end
        reset = 1'b0;
        #1;
        tests++; if (out_wr !== 1'b0 || busy !== 1'b0 || tx_pkts !== '0 || tx_words !== '0) begin
            fails++; $display("FAIL midrst_clear: wr=%b busy=%b pkts=%0d words=%0d want 0", out_wr, busy, tx_pkts, tx_words); end
        @(negedge clk); reset = 1'b1;
        program_mem(26);
        num_pkts = 32'd1;
        for (int i = 0; i < 14; i++) exp_q.push_back(word_of(i));
        do_start();
        run_collect(100, 1'b0, 0, 1'b0, 1'b0, 6);
        tests++; if (timed_out || got_q.size() != 14) begin
            fails++; $display("FAIL midrst_replay_count: got %0d words want 14", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL midrst_word: got %h want %h", g, e); end
        end
        exp_q.delete();
        tests++; if (tx_pkts !== 32'd1 || tx_words !== 32'd14) begin
            fails++; $display("FAIL midrst_stats: pkts=%0d words=%0d want 1 14", tx_pkts, tx_words); end
    endtask

    task automatic test_throttle;
        @(negedge clk); rdy_period = 8'd5;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); #1;
            tests++; if (dn_rdy !== (i % 5 != 0)) begin
                fails++; $display("FAIL thr_p5 cycle %0d: got %b want %b", i, dn_rdy, (i % 5 != 0)); end
        end
        rdy_period = 8'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            tests++; if (dn_rdy !== 1'b1) begin
                fails++; $display("FAIL thr_p0 cycle %0d: got %b want 1", i, dn_rdy); end
        end
    endtask

    task automatic test_busy_ignore;
        logic [CW+DW-1:0] e, g;
        for (int i = 0; i < 3; i++) begin
            pd[i] = 64'h6666_0000_0000_0000 + 64'(i); pc[i] = '0; pl[i] = 1'b0;
        end
        program_mem(3);
        mem_words = 7'd3; gap_cycles = 8'd0; num_pkts = 32'd2;
        for (int i = 0; i < 6; i++) exp_q.push_back(word_of(i % 3));
        do_start();
        run_collect(100, 1'b0, 0, 1'b1, 1'b1, 0);
        tests++; if (timed_out || got_q.size() != 6) begin
            fails++; $display("FAIL busy_count: got %0d words want 6", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); tests++;
            if (g !== e) begin fails++; $display("FAIL busy_word: got %h want %h", g, e); end
        end
        exp_q.delete();
        tests++; if (tx_pkts !== 32'd2 || tx_words !== 32'd6) begin
            fails++; $display("FAIL busy_stats: pkts=%0d words=%0d want 2 6", tx_pkts, tx_words); end
        @(negedge clk); start = 1'b0; #1;
        tests++; if (busy !== 1'b0 || out_wr !== 1'b0) begin
            fails++; $display("FAIL start_in_done: busy=%b wr=%b want 0 0", busy, out_wr); end
    endtask

    initial begin
        int base_cycles;
        prog_wr = 1'b0; prog_addr = '0; prog_data = '0; prog_ctrl = '0; prog_last = 1'b0;
        mem_words = '0; gap_cycles = '0; num_pkts = '0; rdy_period = 8'd0;
        start = 1'b0; stop = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 26; i++) begin
            pd[i] = 64'hC0DE_0000_0000_0000 + (64'(i) << 32) + 64'(i * 7 + 3);
            pc[i] = (i == 0 || i == 14) ? CTRL_HDR : 8'h00;
            pl[i] = (i == 13 || i == 25);
        end
        test_reset();
        test_basic(base_cycles);
        test_stall(base_cycles);
        test_loop_stop();
        test_mid_reset();
        test_throttle();
        test_busy_ignore();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
